mvprod_seq: RTL

- Sequencer that drives one MVProd instance over a run of consecutive input vectors.
- Gates MVProd on input-vector availability and output-FIFO space, and holds in_data_ready for exactly one vector.
- Counts output chunks, releases each consumed input vector from the input VecFIFO, and reports run completion.
- Sits between the input VecFIFO, MVProd and the output VecFIFO; replaces hand-driven in_data_ready sequencing.

---
 rtl/mvprod_pkg.sv | 23 ++
 rtl/mvprod_seq.sv | 139 +++++++++++++
 2 files changed

// File: rtl/mvprod_pkg.sv
// Shared types and sizing helpers for the MVProd sequencing blocks.
// Pure declarations: no logic, no latency, no flow control.
package mvprod_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_IN,
        RUN,
        POP,
        FINISH
    } state_t;

    // Number of write strobes MVProd emits per output vector.
    function automatic int out_chunks(input int vec_len, input int bytes_per_write);
        return vec_len / bytes_per_write;
    endfunction

    // Bits needed to hold any value in 0..max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/mvprod_seq.sv
// Sequences one MVProd over a run of num_vecs input vectors, popping each consumed vector.
// Latency: start->mv_data_ready 2 cycles best case; last strobe->pop 1 cycle; last pop->done 1 cycle.
// Backpressure: a vector is only launched when the input FIFO holds a vector and the output FIFO has room.
module mvprod_seq
    import mvprod_pkg::*;
#(
    parameter int OutVecLength  = 8,
    parameter int BytesPerWrite = 1,
    parameter int MaxVecs       = 255,
    parameter int TimeoutCycles = 1024
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          start,
    input  logic [$clog2(MaxVecs+1)-1:0]  num_vecs,
    input  logic                          in_vec_avail,
    input  logic                          out_space,
    input  logic                          mv_req_chunk_out,
    input  logic                          mv_out_vector_valid,
    output logic                          mv_data_ready,
    output logic                          in_vec_pop,
    output logic                          busy,
    output logic                          done,
    output logic [$clog2(MaxVecs+1)-1:0]  vec_count,
    output logic                          err
);

    localparam int OutChunks = out_chunks(OutVecLength, BytesPerWrite);
    localparam int VecW      = cnt_width(MaxVecs);
    localparam int ChunkW    = cnt_width(OutChunks);
    localparam int TmoW      = cnt_width(TimeoutCycles);

    localparam logic [ChunkW-1:0] ChunkLast = ChunkW'(OutChunks);
    localparam logic [TmoW-1:0]   TmoLimit  = TmoW'(TimeoutCycles);

    state_t            state_q, state_d;
    logic [ChunkW-1:0] chunk_q, chunk_d, chunk_inc;
    logic [TmoW-1:0]   tmo_q, tmo_d, tmo_inc;
    logic [VecW-1:0]   num_q, num_d;
    logic [VecW-1:0]   vec_d;
    logic              err_d;
    logic              done_d;
    logic              final_chunk;

    assign chunk_inc   = chunk_q + 1'b1;
    assign tmo_inc     = (tmo_q == TmoLimit) ? tmo_q : tmo_q + 1'b1;
    assign final_chunk = mv_req_chunk_out && (chunk_inc == ChunkLast);

    always_comb begin
        state_d = state_q;
        chunk_d = chunk_q;
        tmo_d   = tmo_q;
        num_d   = num_q;
        vec_d   = vec_count;
        err_d   = err;
        done_d  = 1'b0;

        // MVProd should only strobe while we hold it in RUN.
        if (mv_req_chunk_out && (state_q != RUN)) begin
            err_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (num_vecs != '0) begin
                        num_d   = num_vecs;
                        vec_d   = '0;
                        err_d   = 1'b0;
                        state_d = WAIT_IN;
                    end else begin
                        done_d  = 1'b1;
                    end
                end
            end
            WAIT_IN: begin
                if (in_vec_avail && out_space) begin
                    chunk_d = '0;
                    tmo_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                tmo_d = tmo_inc;
                if (mv_req_chunk_out) begin
                    chunk_d = chunk_inc;
                end
                if (mv_out_vector_valid && !final_chunk) begin
                    err_d = 1'b1;
                end
                // Completion wins over a timeout landing on the same cycle.
                if (final_chunk) begin
                    vec_d   = vec_count + 1'b1;
                    state_d = POP;
                end else if (tmo_inc == TmoLimit) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            POP: begin
                state_d = (vec_count == num_q) ? FINISH : WAIT_IN;
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q       <= IDLE;
            chunk_q       <= '0;
            tmo_q         <= '0;
            num_q         <= '0;
            vec_count     <= '0;
            err           <= 1'b0;
            done          <= 1'b0;
            busy          <= 1'b0;
            mv_data_ready <= 1'b0;
            in_vec_pop    <= 1'b0;
        end else begin
            state_q       <= state_d;
            chunk_q       <= chunk_d;
            tmo_q         <= tmo_d;
            num_q         <= num_d;
            vec_count     <= vec_d;
            err           <= err_d;
            done          <= done_d || (state_d == FINISH);
            busy          <= (state_d != IDLE);
            mv_data_ready <= (state_d == RUN);
            in_vec_pop    <= (state_d == POP);
        end
    end

endmodule
